// File: rtl/burst_seq_pkg.sv
// Shared types, constants and helpers for the burst address sequencer.
package burst_seq_pkg;

    typedef enum logic [1:0] {
        BurstFixed = 2'b00,
        BurstIncr  = 2'b01,
        BurstWrap  = 2'b10,
        BurstRsvd  = 2'b11
    } burst_e;

    typedef enum logic {
        StIdle,
        StBurst
    } state_e;

    // WRAP bursts may only carry 2, 4, 8 or 16 beats (len = beats - 1).
    localparam int unsigned WrapLen2  = 1;
    localparam int unsigned WrapLen4  = 3;
    localparam int unsigned WrapLen8  = 7;
    localparam int unsigned WrapLen16 = 15;

    function automatic int unsigned max_size(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic logic wrap_len_ok(input int unsigned len);
        return (len == WrapLen2) || (len == WrapLen4) || (len == WrapLen8) || (len == WrapLen16);
    endfunction

endpackage

// File: rtl/burst_addr_step.sv
// Combinational next-beat address and command legality for one AXI4 burst step.
module burst_addr_step
    import burst_seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [2:0]            size,
    input  logic [1:0]            burst,
    output logic [ADDR_WIDTH-1:0] next_addr,
    output logic                  legal
);

    localparam logic [2:0] MaxSize = 3'(max_size(DATA_WIDTH));

    logic [ADDR_WIDTH-1:0] bytes;
    logic [ADDR_WIDTH-1:0] wrap_mask;

    always_comb begin
        bytes     = ADDR_WIDTH'(1) << size;
        wrap_mask = ((ADDR_WIDTH'(len) + ADDR_WIDTH'(1)) << size) - ADDR_WIDTH'(1);
        legal     = (size <= MaxSize) && (burst_e'(burst) != BurstRsvd);
        next_addr = addr;
        case (burst_e'(burst))
            BurstIncr: next_addr = (addr & ~(bytes - ADDR_WIDTH'(1))) + bytes;
            BurstWrap: begin
                next_addr = (addr & ~wrap_mask) | ((addr + bytes) & wrap_mask);
                if (!wrap_len_ok(32'(len)) || ((addr & (bytes - ADDR_WIDTH'(1))) != '0)) begin
                    legal = 1'b0;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/burst_addr_seq.sv
// AXI4 burst address sequencer: one command in, one registered address per beat out.
// Optional byte-lane strobe output enabled by defining BURST_ADDR_SEQ_STRB_EN.
module burst_addr_seq
    import burst_seq_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [LEN_WIDTH-1:0]  cmd_len_i,
    input  logic [2:0]            cmd_size_i,
    input  logic [1:0]            cmd_burst_i,
    output logic                  beat_valid_o,
    input  logic                  beat_ready_i,
    output logic [ADDR_WIDTH-1:0] beat_addr_o,
    output logic [LEN_WIDTH-1:0]  beat_idx_o,
    output logic                  beat_last_o,
    output logic                  beat_err_o,
    output logic                  busy_o
`ifdef BURST_ADDR_SEQ_STRB_EN
    ,
    output logic [DATA_WIDTH/8-1:0] beat_strb_o
`endif
);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  idx_q;
    logic [LEN_WIDTH-1:0]  idx_next;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  last_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] beat_next_addr;
    logic [ADDR_WIDTH-1:0] unused_cmd_next_addr;
    logic                  unused_beat_legal;
    logic                  cmd_legal;
    logic                  beat_fire;
    logic                  cmd_fire;

    burst_addr_step #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_step_beat (
        .addr     (addr_q),
        .len      (len_q),
        .size     (size_q),
        .burst    (burst_q),
        .next_addr(beat_next_addr),
        .legal    (unused_beat_legal)
    );

    burst_addr_step #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH),
        .LEN_WIDTH (LEN_WIDTH)
    ) u_step_cmd (
        .addr     (cmd_addr_i),
        .len      (cmd_len_i),
        .size     (cmd_size_i),
        .burst    (cmd_burst_i),
        .next_addr(unused_cmd_next_addr),
        .legal    (cmd_legal)
    );

    assign beat_valid_o = (state_q == StBurst);
    assign busy_o       = (state_q == StBurst);
    assign beat_fire    = beat_valid_o & beat_ready_i;
    // Accepting on the last beat handshake gives back-to-back bursts with no bubble.
    assign cmd_ready_o  = (state_q == StIdle) | (beat_fire & last_q);
    assign cmd_fire     = cmd_valid_i & cmd_ready_o;
    assign idx_next     = idx_q + LEN_WIDTH'(1);
    assign beat_addr_o  = addr_q;
    assign beat_idx_o   = idx_q;
    assign beat_last_o  = last_q;
    assign beat_err_o   = err_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            addr_q  <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            size_q  <= '0;
            burst_q <= BurstFixed;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else if (cmd_fire) begin
            state_q <= StBurst;
            addr_q  <= cmd_addr_i;
            len_q   <= cmd_len_i;
            size_q  <= cmd_size_i;
            burst_q <= cmd_burst_i;
            idx_q   <= '0;
            err_q   <= !cmd_legal;
            last_q  <= !cmd_legal || (cmd_len_i == '0);
        end else if (beat_fire) begin
            if (last_q) begin
                state_q <= StIdle;
                last_q  <= 1'b0;
                err_q   <= 1'b0;
            end else begin
                addr_q <= beat_next_addr;
                idx_q  <= idx_next;
                last_q <= (idx_next == len_q);
            end
        end
    end

`ifdef BURST_ADDR_SEQ_STRB_EN
    localparam int unsigned NumLanes = DATA_WIDTH / 8;
    localparam int unsigned MaskW    = NumLanes + 1;

    logic [NumLanes-1:0] strb_q;

    // Lanes from the address lane up to the next size-aligned boundary.
    function automatic logic [NumLanes-1:0] lane_mask(input logic [ADDR_WIDTH-1:0] a,
                                                      input logic [2:0] s);
        int unsigned lo;
        int unsigned hi;
        lo = 32'(a) % NumLanes;
        hi = ((lo >> s) << s) + (32'd1 << s);
        return NumLanes'((MaskW'(1) << hi) - MaskW'(1)) &
               ~NumLanes'((MaskW'(1) << lo) - MaskW'(1));
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            strb_q <= '0;
        end else if (cmd_fire) begin
            strb_q <= cmd_legal ? lane_mask(cmd_addr_i, cmd_size_i) : '0;
        end else if (beat_fire) begin
            strb_q <= last_q ? '0 : lane_mask(beat_next_addr, size_q);
        end
    end

    assign beat_strb_o = strb_q;
`endif

endmodule

// File: tb/tb_burst_addr_seq.sv
// Randomised self-checking bench for burst_addr_seq against a per-burst beat-list model.
module tb_burst_addr_seq;

    localparam int unsigned AW = 12;
    localparam int unsigned DW = 64;
    localparam int unsigned LW = 8;
    localparam int unsigned NB = DW / 8;

    typedef struct {
        int unsigned addr;
        int unsigned len;
        int unsigned size;
        int unsigned burst;
    } cmd_t;

    typedef struct {
        int unsigned addr;
        int unsigned idx;
        int unsigned last;
        int unsigned err;
        int unsigned strb;
    } beat_t;

    logic          clk_i;
    logic          rst_i;
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic [AW-1:0] cmd_addr_i;
    logic [LW-1:0] cmd_len_i;
    logic [2:0]    cmd_size_i;
    logic [1:0]    cmd_burst_i;
    logic          beat_valid_o;
    logic          beat_ready_i;
    logic [AW-1:0] beat_addr_o;
    logic [LW-1:0] beat_idx_o;
    logic          beat_last_o;
    logic          beat_err_o;
    logic          busy_o;
`ifdef BURST_ADDR_SEQ_STRB_EN
    logic [NB-1:0] beat_strb_o;
`endif

    beat_t exp_q[$];
    int    n_checks;
    int    n_fails;

    burst_addr_seq #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .LEN_WIDTH (LW)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_len_i   (cmd_len_i),
        .cmd_size_i  (cmd_size_i),
        .cmd_burst_i (cmd_burst_i),
        .beat_valid_o(beat_valid_o),
        .beat_ready_i(beat_ready_i),
        .beat_addr_o (beat_addr_o),
        .beat_idx_o  (beat_idx_o),
        .beat_last_o (beat_last_o),
        .beat_err_o  (beat_err_o),
        .busy_o      (busy_o)
`ifdef BURST_ADDR_SEQ_STRB_EN
        ,
        .beat_strb_o (beat_strb_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic cmd_t mk(input int unsigned addr, input int unsigned len,
                                input int unsigned size, input int unsigned burst);
        cmd_t c;
        c.addr  = addr;
        c.len   = len;
        c.size  = size;
        c.burst = burst;
        return c;
    endfunction

    function automatic int unsigned lane_strb(input int unsigned a, input int unsigned s);
        int unsigned b;
        int unsigned lo;
        int unsigned hi;
        b  = 1 << s;
        lo = a % NB;
        hi = (lo / b) * b + b;
        return ((1 << hi) - 1) & ~((1 << lo) - 1);
    endfunction

    // Expand a command into its full list of expected beats.
    task automatic push_cmd(input cmd_t c);
        int unsigned b;
        int unsigned total;
        int unsigned lower;
        bit          ok;
        beat_t       bt;
        b  = 1 << c.size;
        ok = (c.size <= $clog2(NB)) && (c.burst != 3);
        if (c.burst == 2) begin
            if (!(c.len == 1 || c.len == 3 || c.len == 7 || c.len == 15)) ok = 0;
            if (c.addr % b != 0) ok = 0;
        end
        if (!ok) begin
            bt.addr = c.addr; bt.idx = 0; bt.last = 1; bt.err = 1; bt.strb = 0;
            exp_q.push_back(bt);
            return;
        end
        total = (c.len + 1) * b;
        lower = (c.addr / total) * total;
        for (int unsigned i = 0; i <= c.len; i++) begin
            case (c.burst)
                0:       bt.addr = c.addr;
                1:       bt.addr = (i == 0) ? c.addr : ((c.addr / b) * b + i * b) % (1 << AW);
                default: bt.addr = lower + (c.addr - lower + i * b) % total;
            endcase
            bt.idx  = i;
            bt.last = (i == c.len) ? 1 : 0;
            bt.err  = 0;
            bt.strb = lane_strb(bt.addr, c.size);
            exp_q.push_back(bt);
        end
    endtask

    // One clock: drive at the falling edge, check, update the model, wait for the next fall.
    task automatic cycle(input logic cv, input cmd_t c, input logic rdy, output logic acc);
        logic exp_rdy;
        cmd_valid_i  = cv;
        cmd_addr_i   = AW'(c.addr);
        cmd_len_i    = LW'(c.len);
        cmd_size_i   = 3'(c.size);
        cmd_burst_i  = 2'(c.burst);
        beat_ready_i = rdy;
        #1;
        check_eq("beat_valid", beat_valid_o, exp_q.size() != 0);
        check_eq("busy", busy_o, exp_q.size() != 0);
        if (exp_q.size() != 0) begin
            check_eq("beat_addr", beat_addr_o, exp_q[0].addr);
            check_eq("beat_idx", beat_idx_o, exp_q[0].idx);
            check_eq("beat_last", beat_last_o, exp_q[0].last);
            check_eq("beat_err", beat_err_o, exp_q[0].err);
`ifdef BURST_ADDR_SEQ_STRB_EN
            check_eq("beat_strb", beat_strb_o, exp_q[0].strb);
`endif
        end
        exp_rdy = (exp_q.size() == 0) || (rdy && exp_q[0].last == 1);
        check_eq("cmd_ready", cmd_ready_o, exp_rdy);
        acc = cv && exp_rdy;
        if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
        if (acc) push_cmd(c);
        @(negedge clk_i);
    endtask

    task automatic issue(input cmd_t c);
        logic acc;
        acc = 1'b0;
        for (int k = 0; k < 300 && !acc; k++) cycle(1'b1, c, 1'b1, acc);
    endtask

    task automatic drain();
        logic acc;
        cmd_t idle_c;
        idle_c = mk(0, 0, 0, 0);
        for (int k = 0; k < 300 && exp_q.size() != 0; k++) cycle(1'b0, idle_c, 1'b1, acc);
        cycle(1'b0, idle_c, 1'b1, acc);
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.burst = $urandom_range(0, 3);
        c.size  = $urandom_range(0, 4);
        if ($urandom_range(0, 2) == 0) c.len = $urandom_range(0, 20);
        else c.len = (1 << $urandom_range(1, 4)) - 1;
        c.addr = $urandom_range(0, (1 << AW) - 1);
        if ($urandom_range(0, 3) != 0) c.addr = c.addr & ~((1 << c.size) - 1);
        return c;
    endfunction

    initial begin
        logic acc;
        cmd_t c;
        n_checks     = 0;
        n_fails      = 0;
        rst_i        = 1'b1;
        cmd_valid_i  = 1'b0;
        cmd_addr_i   = '0;
        cmd_len_i    = '0;
        cmd_size_i   = '0;
        cmd_burst_i  = '0;
        beat_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_eq("rst_cmd_ready", cmd_ready_o, 1);
        check_eq("rst_beat_valid", beat_valid_o, 0);
        check_eq("rst_busy", busy_o, 0);
        check_eq("rst_beat_addr", beat_addr_o, 0);
        check_eq("rst_beat_idx", beat_idx_o, 0);
        check_eq("rst_beat_last", beat_last_o, 0);
        check_eq("rst_beat_err", beat_err_o, 0);
        @(negedge clk_i);

        issue(mk('h104, 3, 2, 1)); drain();
        issue(mk('h038, 3, 3, 2)); drain();
        issue(mk('h038, 2, 3, 2)); drain();
        issue(mk('h055, 2, 0, 0)); drain();
        issue(mk('h103, 1, 2, 1)); drain();
        issue(mk('hFFE, 3, 0, 1)); drain();
        issue(mk('h100, 3, 4, 1)); drain();
        issue(mk('h200, 3, 3, 3)); drain();

        // Stall mid-burst: outputs must hold while ready is low.
        c = mk('h300, 7, 2, 1);
        issue(c);
        cycle(1'b0, c, 1'b1, acc);
        repeat (3) cycle(1'b0, c, 1'b0, acc);
        drain();

        // Second command waiting during the first burst's last beat.
        issue(mk('h400, 2, 1, 1));
        issue(mk('h040, 3, 2, 2));
        drain();

        // Reset during the third beat of an 8-beat INCR.
        c = mk('h500, 7, 2, 1);
        issue(c);
        cycle(1'b0, c, 1'b1, acc);
        cycle(1'b0, c, 1'b1, acc);
        rst_i        = 1'b1;
        cmd_valid_i  = 1'b0;
        beat_ready_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
        exp_q.delete();
        cycle(1'b0, c, 1'b1, acc);
        issue(mk('h600, 3, 1, 1));
        drain();

        for (int n = 0; n < 1500; n++) begin
            c = rand_cmd();
            cycle(1'($urandom_range(0, 1)), c, 1'($urandom_range(0, 3) != 0), acc);
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/burst_addr_seq.md
Name: burst_addr_seq

Overview:
Sequential AXI4 burst address sequencer, parametrised in address, data and length width. Accepts one burst command (addr/len/size/burst) over a valid/ready handshake. Emits one registered beat address per beat on a second valid/ready handshake, with beat index, last and error flags. Sits between the AXI4 slave channel front-end (AW/AR capture) and the SRAM array port; replaces per-beat combinational next-address logic.

Parameters:
ADDR_WIDTH, 12, byte-address offset width
DATA_WIDTH, 64, data bus width in bits; power of 2, 8..1024; MAX_SIZE = log2(DATA_WIDTH/8)
LEN_WIDTH, 8, AxLEN width; beats = len+1

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_addr_i  in  ADDR_WIDTH  start byte address
cmd_len_i  in  LEN_WIDTH  beats minus one
cmd_size_i  in  3  log2 bytes per beat
cmd_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved
beat_valid_o  out  1  beat address valid
beat_ready_i  in  1  consumer accepts beat
beat_addr_o  out  ADDR_WIDTH  byte address of current beat
beat_idx_o  out  LEN_WIDTH  beat number, 0-based
beat_last_o  out  1  final beat of burst
beat_err_o  out  1  command was illegal; beat is a single error beat
busy_o  out  1  burst in progress

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port clk_i, reset port rst_i.
- Reset: state IDLE. All outputs 0 except cmd_ready_o=1. Internal counters 0. Reset mid-burst aborts immediately; no further beats.
- States: IDLE, BURST.
  - IDLE: cmd_ready_o=1. On accept -> BURST.
  - BURST: beat_valid_o=1. On beat handshake with beat_last_o=1 -> IDLE, unless a command is accepted the same cycle -> stay in BURST.
- cmd_ready_o = (state==IDLE) | (beat_valid_o & beat_ready_i & beat_last_o). Back-to-back bursts have zero bubble.
- Latency: command accepted in cycle N -> first beat valid in cycle N+1 with beat_addr_o = cmd_addr_i unmodified (unaligned start kept), beat_idx_o=0.
- Stall: while beat_valid_o & ~beat_ready_i, all beat_* outputs are held stable.
- Advance on each beat handshake: idx+1; beat_last_o = (idx_next == len).
- Next address, with B = 1<<size:
  - FIXED: address unchanged.
  - INCR: aligned = addr & ~(B-1); next = aligned + B, modulo 2^ADDR_WIDTH (wraps silently).
  - WRAP: mask = (len+1)*B - 1; next = (addr & ~mask) | ((addr + B) & mask).
- Illegal command, any of:
  - size > MAX_SIZE
  - burst==11
  - WRAP with len not in {1,3,7,15}
  - WRAP with start not aligned to B
  - Response: accepted normally; exactly one beat issued at cmd_addr_i with beat_err_o=1, beat_last_o=1, beat_idx_o=0.
- busy_o = (state==BURST).

Optional Feature:
Macro BURST_ADDR_SEQ_STRB_EN.
- Defined: adds output beat_strb_o [DATA_WIDTH/8-1:0], registered with the beat. It is the byte-lane mask from addr lane (addr mod DATA_WIDTH/8) up to the next B-aligned boundary. Error beats give all zeros.
- Undefined: port and logic absent; no other behaviour changes.

Decomposition:
- Package burst_seq_pkg:
  - burst type enum (FIXED/INCR/WRAP/RSVD)
  - state enum (IDLE/BURST)
  - WRAP legal-length constants
  - function clog2-based MAX_SIZE helper
- One combinational sub-module burst_addr_step: inputs addr, len, size, burst; outputs next_addr and legal flag. The parent instantiates it once on the registered beat address and once for command legality.

Test Plan:
- DATA_WIDTH=64, INCR size=2 len=3 addr 0x104, beat_ready_i tied 1 -> addrs 0x104,0x108,0x10C,0x110; idx 0..3; last only on 4th; first beat one cycle after accept.
- WRAP size=3 len=3 addr 0x038 -> 0x038,0x020,0x028,0x030; last on 0x030. Repeat with len=2 -> single beat 0x038, err=1, last=1.
- FIXED len=2 addr 0x055 size=0 -> 0x055 three times, idx 0,1,2. INCR size=2 len=1 addr 0x103 -> 0x103,0x104. With BURST_ADDR_SEQ_STRB_EN: strb 0x08 then 0xF0.
- Backpressure: beat_ready_i low 3 cycles mid-burst -> addr/idx/last stable. Second command offered during last beat -> accepted that cycle; its first beat valid next cycle, no idle cycle.
- INCR size=0 len=3 addr 0xFFE (ADDR_WIDTH=12) -> 0xFFE,0xFFF,0x000,0x001. size=4 on 64-bit bus -> one error beat.
- Assert rst_i during beat 2 of an 8-beat INCR -> next cycle beat_valid_o=0, cmd_ready_o=1, busy_o=0. New command starts clean at idx 0.
